password_checker: RTL and testbench

PASSWORD_CHECKER -- requirements
Module: password_checker

---
 rtl/password_checker.sv | 120 ++++++++++++
 tb/tb_password_checker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/password_checker.sv
// password_checker: two-stage compare pipeline that gates an upstream brute-force generator.
// Define PASSWORD_CHECKER_CASE_FOLD_EN to fold ASCII upper case to lower case before comparing.
module password_checker #(
    parameter int ATTEMPT_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [127:0]         targetPassword,
    input  logic [4:0]           targetLength,
    input  logic [ATTEMPT_W-1:0] maxAttempts,
    input  logic [127:0]         candidate,
    input  logic                 candidateValid,
    output logic                 enable,
    output logic                 busy,
    output logic                 found,
    output logic                 done,
    output logic [127:0]         matchPassword,
    output logic [ATTEMPT_W-1:0] attemptCount
);
    typedef enum logic [2:0] {IDLE, SEARCH, FLUSH, FOUND, EXHAUSTED} state_t;
    state_t state;
    logic [127:0] tgt, s1_cand, s2_cand;
    logic [4:0] tgt_len;
    logic [ATTEMPT_W-1:0] max_att, cnt_inc;
    logic s1_valid, s2_hit, flush_last, hit;
    logic [15:0] byte_ok;

    function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef PASSWORD_CHECKER_CASE_FOLD_EN
        return (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
`else
        return b;
`endif
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign byte_ok[i] = (tgt_len <= 5'(i)) || (fold(s1_cand[8*i +: 8]) == fold(tgt[8*i +: 8]));
    end
    assign hit = &byte_ok;
    assign cnt_inc = &attemptCount ? attemptCount : attemptCount + ATTEMPT_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            enable        <= 1'b0;
            busy          <= 1'b0;
            found         <= 1'b0;
            done          <= 1'b0;
            matchPassword <= '0;
            attemptCount  <= '0;
            s1_valid      <= 1'b0;
            s2_hit        <= 1'b0;
            flush_last    <= 1'b0;
        end else if (abort) begin
            state    <= IDLE;
            enable   <= 1'b0;
            busy     <= 1'b0;
            found    <= 1'b0;
            done     <= 1'b0;
            s1_valid <= 1'b0;
            s2_hit   <= 1'b0;
        end else begin
            s1_valid <= 1'b0;
            s2_hit   <= s1_valid && hit;
            s2_cand  <= s1_cand;
            case (state)
                IDLE, FOUND, EXHAUSTED: begin
                    s2_hit <= 1'b0;
                    if (start) begin
                        tgt          <= targetPassword;
                        tgt_len      <= targetLength;
                        max_att      <= maxAttempts;
                        attemptCount <= '0;
                        found        <= 1'b0;
                        if (targetLength == 5'd0 || targetLength > 5'd16 || maxAttempts == '0) begin
                            state <= EXHAUSTED;
                            done  <= 1'b1;
                        end else begin
                            state  <= SEARCH;
                            done   <= 1'b0;
                            enable <= 1'b1;
                            busy   <= 1'b1;
                        end
                    end
                end
                SEARCH, FLUSH: begin
                    if (s2_hit) begin
                        state         <= FOUND;
                        matchPassword <= s2_cand;
                        found         <= 1'b1;
                        done          <= 1'b1;
                        enable        <= 1'b0;
                        busy          <= 1'b0;
                        s2_hit        <= 1'b0;
                    end else if (state == FLUSH) begin
                        flush_last <= 1'b1;
                        if (flush_last) begin
                            state <= EXHAUSTED;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else if (candidateValid) begin
                        s1_valid     <= 1'b1;
                        s1_cand      <= candidate;
                        attemptCount <= cnt_inc;
                        // the limit is reached on this attempt; drain the pipeline before deciding
                        if (cnt_inc == max_att) begin
                            state      <= FLUSH;
                            enable     <= 1'b0;
                            flush_last <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_password_checker.sv
// tb_password_checker: directed vectors with hand-computed expectations for password_checker.
module tb_password_checker;
    logic clock = 1'b0;
    logic reset, start, abort, candidateValid;
    logic [127:0] targetPassword, candidate, matchPassword;
    logic [4:0] targetLength;
    logic [31:0] maxAttempts, attemptCount;
    logic enable, busy, found, done;
    int vectors = 0;
    int errors = 0;

    password_checker dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .targetPassword(targetPassword), .targetLength(targetLength),
        .maxAttempts(maxAttempts), .candidate(candidate),
        .candidateValid(candidateValid), .enable(enable), .busy(busy),
        .found(found), .done(done), .matchPassword(matchPassword),
        .attemptCount(attemptCount)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic arm(input logic [127:0] tp, input logic [4:0] len, input logic [31:0] mx);
        targetPassword = tp;
        targetLength   = len;
        maxAttempts    = mx;
        start          = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic present(input logic [127:0] c);
        candidate      = c;
        candidateValid = 1'b1;
        tick();
        candidateValid = 1'b0;
    endtask

    logic exp_fold;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; candidateValid = 1'b0;
        targetPassword = '0; targetLength = '0; maxAttempts = '0; candidate = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_enable", enable, 0);
        check("rst_found", found, 0);
        check("rst_done", done, 0);
        check("rst_count", attemptCount, 0);
        check("rst_match", matchPassword, 0);

        // "abc" as the 5th candidate
        arm(128'h636261, 5'd3, 32'd100);
        check("search_busy", busy, 1);
        check("search_enable", enable, 1);
        present(128'h616263);
        present(128'h646261);
        present(128'h636161);
        present(128'h6362);
        present(128'h636261);
        check("abc_found_e0", found, 0);
        tick();
        check("abc_found_e1", found, 0);
        tick();
        check("abc_found_e2", found, 1);
        check("abc_done", done, 1);
        check("abc_enable", enable, 0);
        check("abc_count", attemptCount, 5);
        check("abc_match", matchPassword, 128'h636261);
        tick(); tick();
        check("abc_hold_found", found, 1);
        check("abc_hold_count", attemptCount, 5);

        // upper bytes beyond targetLength are ignored
        arm(128'h6261, 5'd2, 32'd10);
        check("len2_cleared_found", found, 0);
        present(128'hFF6261);
        tick(); tick();
        check("len2_found", found, 1);
        check("len2_match", matchPassword, 128'hFF6261);
        check("len2_count", attemptCount, 1);

        // exhaustion after 4 misses, matching candidates during FLUSH are ignored
        arm(128'h636261, 5'd3, 32'd4);
        present(128'h1); present(128'h2); present(128'h3); present(128'h4);
        check("flush_busy", busy, 1);
        check("flush_enable", enable, 0);
        candidate = 128'h636261; candidateValid = 1'b1;
        tick();
        check("flush_done_e4", done, 0);
        tick();
        candidateValid = 1'b0;
        check("exh_done", done, 1);
        check("exh_found", found, 0);
        check("exh_count", attemptCount, 4);
        check("exh_busy", busy, 0);
        tick();
        check("exh_hold_found", found, 0);

        // last permitted attempt matches
        arm(128'h636261, 5'd3, 32'd4);
        present(128'h1); present(128'h2); present(128'h3); present(128'h636261);
        tick(); tick();
        check("last_found", found, 1);
        check("last_done", done, 1);
        check("last_count", attemptCount, 4);

        // abort beats start; attemptCount kept
        arm(128'h636261, 5'd3, 32'd100);
        present(128'h1);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_enable", enable, 0);
        check("abort_count", attemptCount, 1);
        tick();
        check("abort_stays_idle", busy, 0);

        // reset mid-compare suppresses the found pulse
        arm(128'h636261, 5'd3, 32'd100);
        present(128'h636261);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick();
        check("rst_mid_found", found, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_count", attemptCount, 0);

        // upper-case candidate against lower-case target
`ifdef PASSWORD_CHECKER_CASE_FOLD_EN
        exp_fold = 1'b1;
`else
        exp_fold = 1'b0;
`endif
        arm(128'h636261, 5'd3, 32'd100);
        present(128'h434241);
        tick(); tick();
        check("fold_found", found, exp_fold);
        if (exp_fold) check("fold_match", matchPassword, 128'h434241);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // invalid arm parameters go straight to EXHAUSTED
        arm(128'h636261, 5'd0, 32'd100);
        check("len0_done", done, 1);
        check("len0_found", found, 0);
        check("len0_count", attemptCount, 0);
        check("len0_busy", busy, 0);
        arm(128'h636261, 5'd17, 32'd100);
        check("len17_done", done, 1);
        check("len17_busy", busy, 0);
        arm(128'h636261, 5'd3, 32'd0);
        check("max0_done", done, 1);
        check("max0_enable", enable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
